// File: rtl/asrv32_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : asrv32_membus_arbiter
// Description : Round-robin arbiter sharing one single-port memory bus between
//               the instruction-fetch (IF) and load/store (LS) ports. One
//               transaction in flight at a time; payload is latched on grant,
//               the memory ack is forwarded to the winner, and a missing ack
//               is turned into an error completion after MAX_WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module asrv32_membus_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // instruction-fetch port
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_ack,
  // load/store port
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic        i_ls_wr_en,
  input  logic [3:0]  i_ls_wr_mask,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_ack,
  // memory bus
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wr_en,
  output logic [3:0]  o_mem_wr_mask,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  // status
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
  localparam logic       c_grant_if = 1'b0;
  localparam logic       c_grant_ls = 1'b1;

  // Registered state. r_last_grant doubles as the identity of the current
  // winner while BUSY/RESP, because it is updated on every grant.
  state_t      r_state;
  logic        r_last_grant;
  logic [7:0]  r_wait_cnt;

  // Next-state values for every register, including the registered outputs
  state_t      w_state_nxt;
  logic        w_last_grant_nxt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [7:0]  w_wait_inc;
  logic        w_grant_ls;
  logic [31:0] w_resp_data;
  logic [31:0] w_if_rdata_nxt;
  logic        w_if_ack_nxt;
  logic [31:0] w_ls_rdata_nxt;
  logic        w_ls_ack_nxt;
  logic        w_mem_req_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic        w_mem_wr_en_nxt;
  logic [3:0]  w_mem_wr_mask_nxt;
  logic        w_err_nxt;
  logic        w_busy_nxt;

  // State and output registers; asynchronous reset abandons any transaction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= c_grant_if;
      r_wait_cnt    <= 8'd0;
      o_if_rdata    <= 32'd0;
      o_if_ack      <= 1'b0;
      o_ls_rdata    <= 32'd0;
      o_ls_ack      <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= 32'd0;
      o_mem_wdata   <= 32'd0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_mask <= 4'd0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      o_if_rdata    <= w_if_rdata_nxt;
      o_if_ack      <= w_if_ack_nxt;
      o_ls_rdata    <= w_ls_rdata_nxt;
      o_ls_ack      <= w_ls_ack_nxt;
      o_mem_req     <= w_mem_req_nxt;
      o_mem_addr    <= w_mem_addr_nxt;
      o_mem_wdata   <= w_mem_wdata_nxt;
      o_mem_wr_en   <= w_mem_wr_en_nxt;
      o_mem_wr_mask <= w_mem_wr_mask_nxt;
      o_err         <= w_err_nxt;
      o_busy        <= w_busy_nxt;
    end
  end

  // Next-state logic: grant/latch in IDLE, wait for ack or timeout in BUSY,
  // expose the completion pulse for exactly one cycle in RESP
  always_comb begin
    w_state_nxt       = r_state;
    w_last_grant_nxt  = r_last_grant;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_wait_inc        = r_wait_cnt + 8'd1;
    // LS wins if alone, or if both request and IF had the last grant
    w_grant_ls        = i_ls_req & (~i_if_req | (r_last_grant == c_grant_if));
    // Stores complete with zero read data; o_mem_wr_en still holds in BUSY
    w_resp_data       = o_mem_wr_en ? 32'd0 : i_mem_rdata;
    w_if_rdata_nxt    = o_if_rdata;
    w_if_ack_nxt      = 1'b0;
    w_ls_rdata_nxt    = o_ls_rdata;
    w_ls_ack_nxt      = 1'b0;
    w_mem_req_nxt     = o_mem_req;
    w_mem_addr_nxt    = o_mem_addr;
    w_mem_wdata_nxt   = o_mem_wdata;
    w_mem_wr_en_nxt   = o_mem_wr_en;
    w_mem_wr_mask_nxt = o_mem_wr_mask;
    w_err_nxt         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_if_req || i_ls_req) begin
          w_state_nxt      = ST_BUSY;
          w_mem_req_nxt    = 1'b1;
          w_last_grant_nxt = w_grant_ls ? c_grant_ls : c_grant_if;
          if (w_grant_ls) begin
            w_mem_addr_nxt    = i_ls_addr;
            w_mem_wdata_nxt   = i_ls_wdata;
            w_mem_wr_en_nxt   = i_ls_wr_en;
            w_mem_wr_mask_nxt = i_ls_wr_en ? i_ls_wr_mask : 4'd0;
          end else begin
            w_mem_addr_nxt    = i_if_addr;
            w_mem_wdata_nxt   = 32'd0;
            w_mem_wr_en_nxt   = 1'b0;
            w_mem_wr_mask_nxt = 4'd0;
          end
        end
      end

      ST_BUSY: begin
        w_wait_cnt_nxt = w_wait_inc;
        // An ack in the same cycle as the limit takes priority over timeout
        if (i_mem_ack) begin
          w_state_nxt       = ST_RESP;
          w_mem_req_nxt     = 1'b0;
          w_mem_addr_nxt    = 32'd0;
          w_mem_wdata_nxt   = 32'd0;
          w_mem_wr_en_nxt   = 1'b0;
          w_mem_wr_mask_nxt = 4'd0;
          if (r_last_grant == c_grant_ls) begin
            w_ls_ack_nxt   = 1'b1;
            w_ls_rdata_nxt = w_resp_data;
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = w_resp_data;
          end
        end else if (w_wait_inc == c_max_wait) begin
          w_state_nxt       = ST_RESP;
          w_err_nxt         = 1'b1;
          w_mem_req_nxt     = 1'b0;
          w_mem_addr_nxt    = 32'd0;
          w_mem_wdata_nxt   = 32'd0;
          w_mem_wr_en_nxt   = 1'b0;
          w_mem_wr_mask_nxt = 4'd0;
          if (r_last_grant == c_grant_ls) begin
            w_ls_ack_nxt   = 1'b1;
            w_ls_rdata_nxt = 32'd0;
          end else begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = 32'd0;
          end
        end
      end

      ST_RESP: begin
        // No grant here so a requester can drop req on seeing its ack
        w_wait_cnt_nxt = 8'd0;
        w_state_nxt    = ST_IDLE;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_asrv32_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_asrv32_membus_arbiter
// Description : Scoreboard bench for asrv32_membus_arbiter. Expected
//               completions are queued in grant order when requests are
//               driven and popped when an ack pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asrv32_membus_arbiter;

  localparam int MAX_WAIT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_if_req, i_ls_req, i_ls_wr_en, i_mem_ack;
  logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
  logic [3:0]  i_ls_wr_mask;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_ack, o_ls_ack, o_mem_req, o_mem_wr_en, o_err, o_busy;
  logic [3:0]  o_mem_wr_mask;

  asrv32_membus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .i_ls_wr_en(i_ls_wr_en), .i_ls_wr_mask(i_ls_wr_mask),
    .o_ls_rdata(o_ls_rdata), .o_ls_ack(o_ls_ack),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_mask(o_mem_wr_mask),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // memory responder controls
  int   mem_lat   = 2;
  bit   mem_never = 1'b0;
  bit   stray     = 1'b0;
  int   req_cnt   = 0;
  int   last_len  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic exp_t mk(input logic is_ls, input logic [31:0] rdata, input logic err,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wr_en, input logic [3:0] mask);
    exp_t e;
    e.is_ls = is_ls; e.rdata = rdata; e.err = err; e.addr = addr;
    e.wdata = wdata; e.wr_en = wr_en; e.mask = mask;
    return e;
  endfunction

  // Memory model: acks on the mem_lat-th cycle of o_mem_req, checks the bus
  // payload against the transaction at the head of the scoreboard
  initial begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge i_clk);
      #1;
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'hDEAD_BEEF;
      if (o_mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (sb_q.size() == 0) begin
            check_eq("grant_without_request", 64'(o_mem_req), 64'(0));
          end else begin
            check_eq("mem_addr",  64'(o_mem_addr),    64'(sb_q[0].addr));
            check_eq("mem_wdata", 64'(o_mem_wdata),   64'(sb_q[0].wdata));
            check_eq("mem_wr_en", 64'(o_mem_wr_en),   64'(sb_q[0].wr_en));
            check_eq("mem_mask",  64'(o_mem_wr_mask), 64'(sb_q[0].mask));
            check_eq("busy",      64'(o_busy),        64'(1));
          end
        end
        if (!mem_never && req_cnt == mem_lat) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem_data(o_mem_addr);
          if (sb_q.size() != 0)
            check_eq("mem_addr_hold", 64'(o_mem_addr), 64'(sb_q[0].addr));
        end
      end else begin
        if (req_cnt != 0) last_len = req_cnt;
        req_cnt = 0;
        if (stray) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = 32'h5A5A_5A5A;
        end
      end
    end
  end

  // Completion monitor: every ack pulse pops one expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_if_ack || o_ls_ack) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_ack", 64'({o_ls_ack, o_if_ack}), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check_eq("ack_port", 64'({o_ls_ack, o_if_ack}), e.is_ls ? 64'(2) : 64'(1));
            check_eq("rdata", e.is_ls ? 64'(o_ls_rdata) : 64'(o_if_rdata), 64'(e.rdata));
            check_eq("err", 64'(o_err), 64'(e.err));
          end
        end else if (o_err) begin
          check_eq("err_without_ack", 64'(o_err), 64'(0));
        end
      end
    end
  end

  task automatic if_txn(input logic [31:0] a);
    bit got = 1'b0;
    i_if_req  = 1'b1;
    i_if_addr = a;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_if_ack) begin got = 1'b1; break; end
    end
    if (!got) check_eq("if_ack_timeout", 64'(0), 64'(1));
    i_if_req = 1'b0;
  endtask

  task automatic ls_txn(input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [3:0] m);
    bit got = 1'b0;
    i_ls_req     = 1'b1;
    i_ls_addr    = a;
    i_ls_wdata   = wd;
    i_ls_wr_en   = we;
    i_ls_wr_mask = m;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_ls_ack) begin got = 1'b1; break; end
    end
    if (!got) check_eq("ls_ack_timeout", 64'(0), 64'(1));
    i_ls_req = 1'b0;
  endtask

  task automatic wait_mem_req();
    bit got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_mem_req) begin got = 1'b1; break; end
    end
    if (!got) check_eq("mem_req_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, 64'({o_mem_req, o_mem_wr_en, o_mem_wr_mask, o_err,
                                  o_busy, o_if_ack, o_ls_ack}), 64'(0));
    check_eq({tag, "_addr"},  64'(o_mem_addr),  64'(0));
    check_eq({tag, "_wdata"}, 64'(o_mem_wdata), 64'(0));
    check_eq({tag, "_rdata"}, {o_if_rdata, o_ls_rdata}, 64'(0));
  endtask

  initial begin
    i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_addr = '0; i_ls_wdata = '0;
    i_ls_wr_en = 1'b0; i_ls_wr_mask = '0;

    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // IF fetch from 0x100
    mem_lat = 2;
    sb_q.push_back(mk(1'b0, 32'h13, 1'b0, 32'h100, 32'h0, 1'b0, 4'h0));
    if_txn(32'h100);

    // Simultaneous pair after reset: LS wins, then IF
    @(posedge i_clk); #1;
    sb_q.push_back(mk(1'b1, mem_data(32'h400), 1'b0, 32'h400, 32'h0, 1'b0, 4'h0));
    sb_q.push_back(mk(1'b0, mem_data(32'h104), 1'b0, 32'h104, 32'h0, 1'b0, 4'h0));
    fork
      ls_txn(32'h400, 32'h0, 1'b0, 4'h0);
      if_txn(32'h104);
    join

    // A lone LS grant leaves last_grant=LS, so the next pair goes IF first
    @(posedge i_clk); #1;
    mem_lat = 1;
    sb_q.push_back(mk(1'b1, mem_data(32'h408), 1'b0, 32'h408, 32'h0, 1'b0, 4'h0));
    ls_txn(32'h408, 32'h0, 1'b0, 4'h0);
    @(posedge i_clk); #1;
    sb_q.push_back(mk(1'b0, mem_data(32'h108), 1'b0, 32'h108, 32'h0, 1'b0, 4'h0));
    sb_q.push_back(mk(1'b1, mem_data(32'h40C), 1'b0, 32'h40C, 32'h0, 1'b0, 4'h0));
    fork
      ls_txn(32'h40C, 32'h0, 1'b0, 4'h0);
      if_txn(32'h108);
    join

    // LS store: payload passes through, read data returned as 0
    @(posedge i_clk); #1;
    mem_lat = 3;
    sb_q.push_back(mk(1'b1, 32'h0, 1'b0, 32'h205, 32'h0000_AB00, 1'b1, 4'b0010));
    ls_txn(32'h205, 32'h0000_AB00, 1'b1, 4'b0010);
    check_eq("if_rdata_hold", 64'(o_if_rdata), 64'(mem_data(32'h108)));

    // LS load with no memory ack: timeout after MAX_WAIT busy cycles
    @(posedge i_clk); #1;
    mem_never = 1'b1;
    sb_q.push_back(mk(1'b1, 32'h0, 1'b1, 32'h300, 32'h0, 1'b0, 4'h0));
    ls_txn(32'h300, 32'h0, 1'b0, 4'h0);
    check_eq("timeout_len", 64'(last_len), 64'(MAX_WAIT));
    mem_never = 1'b0;

    // Ack in the same cycle as the limit: normal completion, no error
    @(posedge i_clk); #1;
    mem_lat = MAX_WAIT;
    sb_q.push_back(mk(1'b1, mem_data(32'h600), 1'b0, 32'h600, 32'h0, 1'b0, 4'h0));
    ls_txn(32'h600, 32'h0, 1'b0, 4'h0);
    check_eq("limit_ack_len", 64'(last_len), 64'(MAX_WAIT));

    // Payload change while BUSY is ignored
    @(posedge i_clk); #1;
    mem_lat = 4;
    sb_q.push_back(mk(1'b1, mem_data(32'h500), 1'b0, 32'h500, 32'h0, 1'b0, 4'h0));
    fork
      ls_txn(32'h500, 32'h0, 1'b0, 4'h0);
      begin
        wait_mem_req();
        i_ls_addr = 32'h0000_FFF0;
        @(negedge i_clk);
        check_eq("addr_latched", 64'(o_mem_addr), 64'(32'h500));
      end
    join

    // Stray memory ack while idle must be ignored
    @(posedge i_clk); #1;
    stray = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    stray = 1'b0;
    @(negedge i_clk);
    check_eq("stray_idle_busy", 64'(o_busy), 64'(0));

    // Asynchronous reset in the middle of BUSY: transaction lost, no ack
    @(posedge i_clk); #1;
    mem_never = 1'b1;
    sb_q.push_back(mk(1'b0, 32'h0, 1'b0, 32'h700, 32'h0, 1'b0, 4'h0));
    i_if_req  = 1'b1;
    i_if_addr = 32'h700;
    wait_mem_req();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    i_if_req  = 1'b0;
    mem_never = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Normal IF fetch after reset release
    @(posedge i_clk); #1;
    mem_lat = 2;
    sb_q.push_back(mk(1'b0, mem_data(32'h104), 1'b0, 32'h104, 32'h0, 1'b0, 4'h0));
    if_txn(32'h104);

    repeat (4) @(negedge i_clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
